alu_arbitro: RTL and testbench

- Shares the single RV32I combinational ALU between two requesters: port 0 (main datapath execute) and port 1 (address/branch helper).
- Round-robin arbitration, valid/ready request handshake, registered operands to the ALU, registered result returned on a per-requester response channel.
- Sits between the requesters and one externally instantiated `alu` (drives its a/b/sel, reads its Y).
- Also keeps saturating per-port completed-operation counters.

---
 rtl/alu_arbitro_if.sv | 54 +++++
 rtl/alu_arbitro.sv | 135 +++++++++++++
 tb/tb_alu_arbitro.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbitro_if.sv
// Requester-side bundle of alu_arbitro: two request/response channels plus the shared result.
// ALU_ARB_CERO_EN adds the registered zero flag resp_cero to the bundle.
interface alu_arbitro_if #(
    parameter int ANCHO = 32
);
    logic             req_valid_0;
    logic             req_ready_0;
    logic [ANCHO-1:0] req_a_0;
    logic [ANCHO-1:0] req_b_0;
    logic [3:0]       req_sel_0;
    logic             resp_valid_0;
    logic             resp_ready_0;

    logic             req_valid_1;
    logic             req_ready_1;
    logic [ANCHO-1:0] req_a_1;
    logic [ANCHO-1:0] req_b_1;
    logic [3:0]       req_sel_1;
    logic             resp_valid_1;
    logic             resp_ready_1;

    logic [ANCHO-1:0] resp_y;
`ifdef ALU_ARB_CERO_EN
    logic             resp_cero;

    modport master (
        output req_valid_0, req_a_0, req_b_0, req_sel_0, resp_ready_0,
        output req_valid_1, req_a_1, req_b_1, req_sel_1, resp_ready_1,
        input  req_ready_0, resp_valid_0, req_ready_1, resp_valid_1,
        input  resp_y, resp_cero
    );

    modport slave (
        input  req_valid_0, req_a_0, req_b_0, req_sel_0, resp_ready_0,
        input  req_valid_1, req_a_1, req_b_1, req_sel_1, resp_ready_1,
        output req_ready_0, resp_valid_0, req_ready_1, resp_valid_1,
        output resp_y, resp_cero
    );
`else
    modport master (
        output req_valid_0, req_a_0, req_b_0, req_sel_0, resp_ready_0,
        output req_valid_1, req_a_1, req_b_1, req_sel_1, resp_ready_1,
        input  req_ready_0, resp_valid_0, req_ready_1, resp_valid_1,
        input  resp_y
    );

    modport slave (
        input  req_valid_0, req_a_0, req_b_0, req_sel_0, resp_ready_0,
        input  req_valid_1, req_a_1, req_b_1, req_sel_1, resp_ready_1,
        output req_ready_0, resp_valid_0, req_ready_1, resp_valid_1,
        output resp_y
    );
`endif
endinterface

// File: rtl/alu_arbitro.sv
// Round-robin sharing of one external combinational ALU between two requesters, with
// saturating completion counters. Optional macro ALU_ARB_CERO_EN adds the resp_cero flag.
module alu_arbitro #(
    parameter int ANCHO = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbitro_if.slave     bus,
    output logic [ANCHO-1:0] alu_a,
    output logic [ANCHO-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [ANCHO-1:0] alu_y,
    output logic [CNT_W-1:0] cnt_0,
    output logic [CNT_W-1:0] cnt_1
);

    typedef enum logic [1:0] {
        LIBRE = 2'd0,
        EJEC  = 2'd1,
        RESP  = 2'd2
    } estado_t;

    estado_t          state;
    estado_t          state_next;
    logic             prio;
    logic             dueno;
    logic [ANCHO-1:0] resp_y_q;
    logic             gnt_0;
    logic             gnt_1;
    logic             hecho;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_next = state;
        gnt_0      = 1'b0;
        gnt_1      = 1'b0;
        hecho      = 1'b0;
        case (state)
            LIBRE: begin
                // prio only breaks ties; a lone requester always wins
                gnt_0 = bus.req_valid_0 && (!bus.req_valid_1 || !prio);
                gnt_1 = bus.req_valid_1 && (!bus.req_valid_0 ||  prio);
                if (gnt_0 || gnt_1) begin
                    state_next = EJEC;
                end
            end
            EJEC: begin
                state_next = RESP;
            end
            RESP: begin
                hecho = dueno ? bus.resp_ready_1 : bus.resp_ready_0;
                if (hecho) begin
                    state_next = LIBRE;
                end
            end
            default: begin
                state_next = LIBRE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; reset is synchronous and wins over all else.
        if (rst) begin
            state <= LIBRE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= 1'b0;
            dueno    <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            resp_y_q <= '0;
            cnt_0    <= '0;
            cnt_1    <= '0;
        end else begin
            if (gnt_0) begin
                alu_a   <= bus.req_a_0;
                alu_b   <= bus.req_b_0;
                alu_sel <= bus.req_sel_0;
                dueno   <= 1'b0;
            end else if (gnt_1) begin
                alu_a   <= bus.req_a_1;
                alu_b   <= bus.req_b_1;
                alu_sel <= bus.req_sel_1;
                dueno   <= 1'b1;
            end

            if (state == EJEC) begin
                resp_y_q <= alu_y;
            end

            // Priority moves only when a response completes, giving 0,1,0,1 under contention
            if (hecho) begin
                prio <= ~dueno;
                if (!dueno) begin
                    if (cnt_0 != '1) begin
                        cnt_0 <= cnt_0 + 1'b1;
                    end
                end else begin
                    if (cnt_1 != '1) begin
                        cnt_1 <= cnt_1 + 1'b1;
                    end
                end
            end
        end
    end

`ifdef ALU_ARB_CERO_EN
    logic resp_cero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_cero_q <= 1'b0;
        end else if (state == EJEC) begin
            resp_cero_q <= (alu_y == '0);
        end
    end

    assign bus.resp_cero = resp_cero_q;
`endif

    assign bus.req_ready_0  = gnt_0;
    assign bus.req_ready_1  = gnt_1;
    assign bus.resp_valid_0 = (state == RESP) && !dueno;
    assign bus.resp_valid_1 = (state == RESP) &&  dueno;
    assign bus.resp_y       = resp_y_q;

endmodule

// File: tb/tb_alu_arbitro.sv
// Self-checking bench for alu_arbitro: directed table, contention, backpressure, reset,
// saturation (CNT_W=2 instance) and randomized traffic against a transaction-level model.
module tb_alu_arbitro;

    localparam int ANCHO = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Main instance
    alu_arbitro_if #(.ANCHO(ANCHO)) bus ();
    logic [ANCHO-1:0] alu_a, alu_b, alu_y;
    logic [3:0]       alu_sel;
    logic [15:0]      cnt_0, cnt_1;

    alu_arbitro #(.ANCHO(ANCHO), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_y   (alu_y),
        .cnt_0   (cnt_0),
        .cnt_1   (cnt_1)
    );

    // Narrow-counter instance for saturation
    alu_arbitro_if #(.ANCHO(ANCHO)) sbus ();
    logic [ANCHO-1:0] s_alu_a, s_alu_b, s_alu_y;
    logic [3:0]       s_alu_sel;
    logic [1:0]       s_cnt_0, s_cnt_1;

    alu_arbitro #(.ANCHO(ANCHO), .CNT_W(2)) u_sat (
        .clk     (clk),
        .rst     (rst),
        .bus     (sbus),
        .alu_a   (s_alu_a),
        .alu_b   (s_alu_b),
        .alu_sel (s_alu_sel),
        .alu_y   (s_alu_y),
        .cnt_0   (s_cnt_0),
        .cnt_1   (s_cnt_1)
    );

    // Stand-in RV32I ALU
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] sel);
        case (sel)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a << b[4:0];
            4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: return (a < b) ? 32'd1 : 32'd0;
            4'b1010: return a >> b[4:0];
            4'b1011: return $signed(a) >>> b[4:0];
            4'b1100: return a ^ b;
            4'b1101: return a | b;
            4'b1110: return a & b;
            default: return b;
        endcase
    endfunction

    always_comb alu_y   = alu_ref(alu_a, alu_b, alu_sel);
    always_comb s_alu_y = alu_ref(s_alu_a, s_alu_b, s_alu_sel);

    // Transaction-level model state
    bit m_prio;
    int m_cnt [2];

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] y;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.req_valid_0 = 1'b0; bus.req_a_0 = '0; bus.req_b_0 = '0; bus.req_sel_0 = '0;
        bus.req_valid_1 = 1'b0; bus.req_a_1 = '0; bus.req_b_1 = '0; bus.req_sel_1 = '0;
        bus.resp_ready_0 = 1'b0;
        bus.resp_ready_1 = 1'b0;
    endtask

    task automatic set_req(input int p, input bit v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel);
        if (p == 0) begin
            bus.req_valid_0 = v; bus.req_a_0 = a; bus.req_b_0 = b; bus.req_sel_0 = sel;
        end else begin
            bus.req_valid_1 = v; bus.req_a_1 = a; bus.req_b_1 = b; bus.req_sel_1 = sel;
        end
    endtask

    task automatic set_rr(input int p, input bit r);
        if (p == 0) bus.resp_ready_0 = r;
        else        bus.resp_ready_1 = r;
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req_ready_0 : bus.req_ready_1;
    endfunction

    function automatic logic rv(input int p);
        return (p == 0) ? bus.resp_valid_0 : bus.resp_valid_1;
    endfunction

    function automatic logic [15:0] cnt(input int p);
        return (p == 0) ? cnt_0 : cnt_1;
    endfunction

    // One full transaction on port p. 'both' also raises the other port at grant time;
    // after the grant the other port keeps requesting and must not be acknowledged.
    task automatic run_op(input string tag, input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel, input logic [31:0] exp_y, input bit both,
                          input int hold);
        int q;
        q = 1 - p;
        @(negedge clk);
        idle();
        set_req(p, 1'b1, a, b, sel);
        set_req(q, both, a ^ 32'h5A5A_5A5A, b, sel);
        #1;
        check({tag, " grant ready"}, rdy(p), 1'b1);
        check({tag, " other ready"}, rdy(q), 1'b0);

        @(negedge clk);
        set_req(p, 1'b0, '0, '0, '0);
        set_req(q, 1'b1, a ^ 32'h5A5A_5A5A, b, sel);
        #1;
        check({tag, " alu_a"}, alu_a, a);
        check({tag, " alu_b"}, alu_b, b);
        check({tag, " alu_sel"}, {28'd0, alu_sel}, {28'd0, sel});
        check({tag, " ejec resp_valid"}, {rv(1), rv(0)}, 2'b00);
        check({tag, " ejec ready"}, rdy(q), 1'b0);

        @(negedge clk);
        #1;
        check({tag, " resp_valid owner"}, rv(p), 1'b1);
        check({tag, " resp_valid other"}, rv(q), 1'b0);
        check({tag, " resp_y"}, bus.resp_y, exp_y);
`ifdef ALU_ARB_CERO_EN
        check({tag, " resp_cero"}, bus.resp_cero, (exp_y == 32'd0));
`endif

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            set_rr(q, 1'b1);
            #1;
            check({tag, " hold resp_valid"}, rv(p), 1'b1);
            check({tag, " hold resp_y"}, bus.resp_y, exp_y);
            check({tag, " hold other ready"}, rdy(q), 1'b0);
        end

        @(negedge clk);
        #1;
        check({tag, " pre-ack resp_valid"}, rv(p), 1'b1);
        set_rr(q, 1'b0);
        set_rr(p, 1'b1);

        @(negedge clk);
        idle();
        m_cnt[p] = (m_cnt[p] == 65535) ? 65535 : m_cnt[p] + 1;
        m_prio   = (p == 0);
        #1;
        check({tag, " cnt owner"}, cnt(p), m_cnt[p][15:0]);
        check({tag, " cnt other"}, cnt(q), m_cnt[q][15:0]);
        check({tag, " done resp_valid"}, {rv(1), rv(0)}, 2'b00);
    endtask

    task automatic reset_model();
        m_prio   = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_exp;
        bit v0, v1;
        int p;
        logic [31:0] ra, rb;
        logic [3:0]  rs;

        tbl[0] = '{0, 32'd5,          32'd7,  4'b0000, 32'd12};
        tbl[1] = '{0, 32'h10,         32'h3,  4'b0001, 32'hD};
        tbl[2] = '{1, 32'hF0,         32'h3C, 4'b1110, 32'h30};
        tbl[3] = '{1, 32'h8000_0000,  32'd4,  4'b1011, 32'hF800_0000};
        tbl[4] = '{0, 32'd3,          32'd9,  4'b0100, 32'd1};
        tbl[5] = '{1, 32'd9,          32'd9,  4'b0001, 32'd0};
        tbl[6] = '{0, 32'hFFFF_FFFF,  32'd1,  4'b0000, 32'd0};
        tbl[7] = '{1, 32'd1,          32'd31, 4'b0010, 32'h8000_0000};

        idle();
        sbus.req_valid_0 = 1'b0; sbus.req_a_0 = '0; sbus.req_b_0 = '0; sbus.req_sel_0 = '0;
        sbus.req_valid_1 = 1'b0; sbus.req_a_1 = '0; sbus.req_b_1 = '0; sbus.req_sel_1 = '0;
        sbus.resp_ready_0 = 1'b0;
        sbus.resp_ready_1 = 1'b0;
        reset_model();

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst req_ready", {bus.req_ready_1, bus.req_ready_0}, 2'b00);
        check("rst resp_valid", {bus.resp_valid_1, bus.resp_valid_0}, 2'b00);
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst alu_sel", {28'd0, alu_sel}, 32'd0);
        check("rst resp_y", bus.resp_y, 32'd0);
        check("rst cnt_0", cnt_0, 16'd0);
        check("rst cnt_1", cnt_1, 16'd0);
`ifdef ALU_ARB_CERO_EN
        check("rst resp_cero", bus.resp_cero, 1'b0);
`endif
        rst = 1'b0;

        // Contention straight after reset: grants alternate from port 0
        for (int r = 0; r < 3; r++) begin
            p = m_prio ? 1 : 0;
            if (p == 0) run_op("contend p0", 0, 32'h10, 32'h3, 4'b0001, 32'hD, 1'b1, 0);
            else        run_op("contend p1", 1, 32'hF0, 32'h3C, 4'b1110, 32'h30, 1'b1, 0);
            check("contend order", p, (r % 2));
        end

        // Saturating counter on the CNT_W=2 instance, port 0 streaming
        @(negedge clk);
        sbus.req_valid_0  = 1'b1;
        sbus.req_a_0      = 32'd1;
        sbus.req_b_0      = 32'd2;
        sbus.req_sel_0    = 4'b0000;
        sbus.resp_ready_0 = 1'b1;
        s_exp = 0;
        for (int i = 0; i < 5; i++) begin
            repeat (3) @(negedge clk);
            #1;
            s_exp = (s_exp == 3) ? 3 : s_exp + 1;
            check("sat cnt_0", {30'd0, s_cnt_0}, s_exp);
        end
        sbus.req_valid_0  = 1'b0;
        sbus.resp_ready_0 = 1'b0;
        check("sat cnt_1", {30'd0, s_cnt_1}, 32'd0);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op("tbl", tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].y, 1'b0, i % 3);
        end

        // Backpressure: port 1 result held 5 cycles while port 0 keeps requesting
        run_op("backpressure", 1, 32'h8000_0000, 32'd4, 4'b1011, 32'hF800_0000, 1'b0, 5);

        // Reset during EJEC drops the request
        @(negedge clk);
        idle();
        set_req(0, 1'b1, 32'd5, 32'd7, 4'b0000);
        #1;
        check("midrst grant", bus.req_ready_0, 1'b1);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        reset_model();
        check("midrst resp_valid", {bus.resp_valid_1, bus.resp_valid_0}, 2'b00);
        check("midrst req_ready", {bus.req_ready_1, bus.req_ready_0}, 2'b00);
        check("midrst alu_a", alu_a, 32'd0);
        check("midrst alu_sel", {28'd0, alu_sel}, 32'd0);
        check("midrst resp_y", bus.resp_y, 32'd0);
        check("midrst cnt_0", cnt_0, 16'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("midrst no late resp", {bus.resp_valid_1, bus.resp_valid_0}, 2'b00);
        run_op("after rst", 0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) begin
                @(negedge clk);
                idle();
                #1;
                check("rnd idle ready", {bus.req_ready_1, bus.req_ready_0}, 2'b00);
            end else begin
                p  = (v0 && v1) ? (m_prio ? 1 : 0) : (v0 ? 0 : 1);
                ra = $urandom;
                rb = $urandom;
                rs = 4'($urandom_range(0, 15));
                run_op("rnd", p, ra, rb, rs, alu_ref(ra, rb, rs), v0 && v1,
                       $urandom_range(0, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
